// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with per-register busy
// scoreboard for RAW hazard detection between decode and writeback.
//
// Ports:
//   CLK      - clock, all state changes on the rising edge
//   RESET    - synchronous active-high reset (clears data and busy bits)
//   RdAddr   - NUM_RD packed read indices, port i at [i*ADDR_W +: ADDR_W]
//   RdData   - NUM_RD packed read data,    port i at [i*DATA_W +: DATA_W]
//   RdBusy   - per read port: addressed register has an outstanding producer
//   WrEn     - per write port enable
//   WrAddr   - NUM_WR packed write indices
//   WrData   - NUM_WR packed write data
//   ClaimEn  - mark ClaimReg busy (instruction issued with that destination)
//   ClaimReg - destination register being claimed

// Per read port: forwarding mux, zero-register masking and busy qualification.
module regfile_mp_rd #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic [ADDR_W-1:0]        rd_addr,
    input  logic [DATA_W-1:0]        st_data,
    input  logic                     st_busy,
    input  logic                     fwd_en,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_busy
);
    logic hit;

    always_comb begin
        rd_data = st_data;
        hit     = 1'b0;
        // Ascending scan: the highest-index matching write port ends up selected,
        // mirroring which port wins the store.
        if (BYPASS != 0 && fwd_en) begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en[j] && wr_addr[j*ADDR_W +: ADDR_W] == rd_addr) begin
                    rd_data = wr_data[j*DATA_W +: DATA_W];
                    hit     = 1'b1;
                end
            end
        end
        if (ZERO_REG != 0 && rd_addr == '0)
            rd_data = '0;
        // A forwarded value resolves the hazard this cycle, so no stall.
        rd_busy = st_busy & ~hit;
    end
endmodule

module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 3,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [NUM_RD*ADDR_W-1:0] RdAddr,
    output logic [NUM_RD*DATA_W-1:0] RdData,
    output logic [NUM_RD-1:0]        RdBusy,
    input  logic [NUM_WR-1:0]        WrEn,
    input  logic [NUM_WR*ADDR_W-1:0] WrAddr,
    input  logic [NUM_WR*DATA_W-1:0] WrData,
    input  logic                     ClaimEn,
    input  logic [ADDR_W-1:0]        ClaimReg
);
    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0] regs_q, regs_d;
    logic [DEPTH-1:0]             busy_q, busy_d;

    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        // Ascending order: the highest-index port overwrites earlier ones.
        for (int j = 0; j < NUM_WR; j++) begin
            if (WrEn[j] && !(ZERO_REG != 0 && WrAddr[j*ADDR_W +: ADDR_W] == '0)) begin
                regs_d[WrAddr[j*ADDR_W +: ADDR_W]] = WrData[j*DATA_W +: DATA_W];
                busy_d[WrAddr[j*ADDR_W +: ADDR_W]] = 1'b0;
            end
        end
        // Claim applied last: the new producer supersedes a retiring one.
        if (ClaimEn && !(ZERO_REG != 0 && ClaimReg == '0))
            busy_d[ClaimReg] = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            regs_q <= '0;
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    // Forwarding is disabled during reset so reads reflect stored state only.
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        regfile_mp_rd #(
            .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_WR(NUM_WR),
            .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
        ) u_rd (
            .rd_addr (RdAddr[i*ADDR_W +: ADDR_W]),
            .st_data (regs_q[RdAddr[i*ADDR_W +: ADDR_W]]),
            .st_busy (busy_q[RdAddr[i*ADDR_W +: ADDR_W]]),
            .fwd_en  (~RESET),
            .wr_en   (WrEn),
            .wr_addr (WrAddr),
            .wr_data (WrData),
            .rd_data (RdData[i*DATA_W +: DATA_W]),
            .rd_busy (RdBusy[i])
        );
    end
endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench: stimulus pushes expected read results, a negedge monitor
// pops and compares. u0 = bypass + zero register, u1 = no bypass, no zero reg.
module tb_regfile_mp;
    localparam int DW = 32, AW = 5, NR = 3, NW = 2;

    logic            CLK = 1'b0;
    logic            RESET;
    logic [NR*AW-1:0] RdAddr;
    logic [NR*DW-1:0] RdData0, RdData1;
    logic [NR-1:0]    RdBusy0, RdBusy1;
    logic [NW-1:0]    WrEn;
    logic [NW*AW-1:0] WrAddr;
    logic [NW*DW-1:0] WrData;
    logic             ClaimEn;
    logic [AW-1:0]    ClaimReg;

    always #5 CLK = ~CLK;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW),
                 .ZERO_REG(1), .BYPASS(1)) u0 (
        .CLK(CLK), .RESET(RESET), .RdAddr(RdAddr), .RdData(RdData0),
        .RdBusy(RdBusy0), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
        .ClaimEn(ClaimEn), .ClaimReg(ClaimReg));

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW),
                 .ZERO_REG(0), .BYPASS(0)) u1 (
        .CLK(CLK), .RESET(RESET), .RdAddr(RdAddr), .RdData(RdData1),
        .RdBusy(RdBusy1), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
        .ClaimEn(ClaimEn), .ClaimReg(ClaimReg));

    typedef struct {
        int          cyc;
        int          dut;
        int          port;
        logic [31:0] data;
        logic        busy;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // Monitor: outputs are combinational, so everything queued this cycle is
    // checked at the falling edge before the next commit.
    always @(negedge CLK) begin
        exp_t e;
        logic [31:0] gd;
        logic        gb;
        while (sb.size() > 0) begin
            e  = sb.pop_front();
            gd = (e.dut == 0) ? RdData0[e.port*DW +: DW] : RdData1[e.port*DW +: DW];
            gb = (e.dut == 0) ? RdBusy0[e.port] : RdBusy1[e.port];
            total++;
            if (gd !== e.data || gb !== e.busy) begin
                bad++;
                $display("FAIL c%0d_u%0d_p%0d: got data=%h busy=%b, want data=%h busy=%b",
                         e.cyc, e.dut, e.port, gd, gb, e.data, e.busy);
            end
        end
    end

    task automatic push(input int dut, input int port, input logic [31:0] d, input logic b);
        exp_t e;
        e.cyc = cyc; e.dut = dut; e.port = port; e.data = d; e.busy = b;
        sb.push_back(e);
    endtask

    // Same expectation on both instances.
    task automatic push2(input int port, input logic [31:0] d, input logic b);
        push(0, port, d, b);
        push(1, port, d, b);
    endtask

    // Advance to just after the next rising edge and return inputs to idle.
    task automatic next_cycle();
        @(posedge CLK);
        #1;
        cyc++;
        RESET = 1'b0; WrEn = '0; WrAddr = '0; WrData = '0;
        ClaimEn = 1'b0; ClaimReg = '0;
    endtask

    task automatic rd(input int p, input int a);
        RdAddr[p*AW +: AW] = a[AW-1:0];
    endtask

    task automatic wr(input int j, input int a, input logic [31:0] d);
        WrEn[j] = 1'b1;
        WrAddr[j*AW +: AW] = a[AW-1:0];
        WrData[j*DW +: DW] = d;
    endtask

    task automatic claim(input int r);
        ClaimEn  = 1'b1;
        ClaimReg = r[AW-1:0];
    endtask

    initial begin
        RESET = 1'b1; RdAddr = '0; WrEn = '0; WrAddr = '0; WrData = '0;
        ClaimEn = 1'b0; ClaimReg = '0;

        // Reset with a write and claim that must both be dropped.
        next_cycle();
        RESET = 1'b1; wr(0, 5, 32'hDEADBEEF); claim(5);
        rd(0, 1); rd(1, 2); rd(2, 3);

        next_cycle();
        rd(0, 1); rd(1, 2); rd(2, 3);
        for (int p = 0; p < NR; p++) push2(p, 32'h0, 1'b0);

        next_cycle();
        rd(0, 5);
        push2(0, 32'h0, 1'b0);

        // Same-cycle write: bypass vs stored value.
        next_cycle();
        wr(0, 7, 32'h12345678); rd(0, 7);
        push(0, 0, 32'h12345678, 1'b0);
        push(1, 0, 32'h0, 1'b0);

        next_cycle();
        rd(0, 7);
        push2(0, 32'h12345678, 1'b0);

        // Write collision on r9: port 1 wins, read on port 2.
        next_cycle();
        wr(0, 9, 32'h1111); wr(1, 9, 32'h2222); rd(2, 9);
        push(0, 2, 32'h2222, 1'b0);
        push(1, 2, 32'h0, 1'b0);

        next_cycle();
        rd(0, 9); rd(2, 9);
        push2(0, 32'h2222, 1'b0);
        push2(2, 32'h2222, 1'b0);

        // Zero register: write and claim r0.
        next_cycle();
        wr(0, 0, 32'hFFFFFFFF); claim(0); rd(0, 0);
        push2(0, 32'h0, 1'b0);

        next_cycle();
        rd(0, 0); rd(1, 0);
        push(0, 0, 32'h0, 1'b0);
        push(0, 1, 32'h0, 1'b0);
        push(1, 0, 32'hFFFFFFFF, 1'b1);
        push(1, 1, 32'hFFFFFFFF, 1'b1);

        // Scoreboard on r4: claim becomes visible the next cycle.
        next_cycle();
        claim(4); rd(0, 4);
        push2(0, 32'h0, 1'b0);

        next_cycle();
        rd(0, 4);
        push2(0, 32'h0, 1'b1);

        next_cycle();
        wr(0, 4, 32'hAB); rd(0, 4);
        push(0, 0, 32'hAB, 1'b0);
        push(1, 0, 32'h0, 1'b1);

        next_cycle();
        rd(0, 4);
        push2(0, 32'hAB, 1'b0);

        // Claim and write r4 together: data updates, busy set.
        next_cycle();
        claim(4); wr(1, 4, 32'hCD); rd(0, 4);
        push(0, 0, 32'hCD, 1'b0);
        push(1, 0, 32'hAB, 1'b0);

        next_cycle();
        rd(0, 4);
        push2(0, 32'hCD, 1'b1);

        // Claims on r3 and r8, then reset mid-flight with a write to r3.
        next_cycle();
        claim(3);

        next_cycle();
        claim(8); rd(0, 3); rd(1, 8);
        push2(0, 32'h0, 1'b1);
        push2(1, 32'h0, 1'b0);

        next_cycle();
        RESET = 1'b1; wr(0, 3, 32'h55); rd(0, 3); rd(1, 8);
        // Forwarding suppressed during reset: stored busy still visible.
        push2(0, 32'h0, 1'b1);
        push2(1, 32'h0, 1'b1);

        next_cycle();
        rd(0, 3); rd(1, 8); rd(2, 4);
        push2(0, 32'h0, 1'b0);
        push2(1, 32'h0, 1'b0);
        push2(2, 32'h0, 1'b0);

        next_cycle();
        @(posedge CLK);
        if (sb.size() != 0) begin
            bad++;
            total++;
            $display("FAIL drain: got %0d unchecked entries, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port general-purpose register file for the pipelined core. It succeeds the fixed 32x32, 3-read/1-write file with:
- configurable width, depth and read/write port counts
- optional hardwired-zero register 0
- optional same-cycle write-to-read bypass
- a per-register busy scoreboard that issue logic uses to detect RAW hazards
Sits between decode (reads, claims) and writeback (writes).

Parameters:
DATA_W, 32, width of each register in bits
ADDR_W, 5, register index width; depth = 2**ADDR_W
NUM_RD, 3, number of read ports
NUM_WR, 2, number of write ports
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never busy
BYPASS, 1, 1 = reads and busy flags see same-cycle writes combinationally

Ports:
CLK  input  1  clock, all state updates on rising edge
RESET  input  1  reset, synchronous, active-high
RdAddr  input  NUM_RD*ADDR_W  read indices, port i at [i*ADDR_W +: ADDR_W]
RdData  output  NUM_RD*DATA_W  read data, port i at [i*DATA_W +: DATA_W]
RdBusy  output  NUM_RD  1 = register addressed by read port i has an outstanding producer
WrEn  input  NUM_WR  write enables
WrAddr  input  NUM_WR*ADDR_W  write indices
WrData  input  NUM_WR*DATA_W  write data
ClaimEn  input  1  mark ClaimReg busy (instruction issued with this destination)
ClaimReg  input  ADDR_W  destination register being claimed

Behaviour:
- Storage: 2**ADDR_W x DATA_W registers plus 2**ADDR_W busy bits.
- Reset: on a rising CLK edge with RESET=1, all registers go to 0 and all busy bits to 0.
  - Writes and claims in that cycle are ignored.
  - While RESET=1, bypass and busy forwarding are suppressed, so reads show stored state only.
  - After the reset edge, every RdData is 0 and every RdBusy is 0.
  - Reset asserted mid-operation discards all pending busy state.
- Read latency:
  - Combinational, zero cycles.
  - BYPASS=0: RdData = stored value (write-first not visible until the next cycle).
  - BYPASS=1: if any WrEn[j] is high with WrAddr[j]==RdAddr[i], RdData[i] = WrData of the highest-index matching j; otherwise the stored value.
- Write: on a rising edge with WrEn[j]=1, Reg[WrAddr[j]] <= WrData[j].
  - If several ports target the same register in one cycle, the highest-index port wins.
- Zero register (ZERO_REG=1): index 0 reads 0 on all ports (bypass included), writes to 0 are dropped, and ClaimReg=0 is ignored. With ZERO_REG=0, index 0 is an ordinary register.
- Scoreboard, per register r on a rising edge:
  - ClaimEn with ClaimReg==r: busy[r] <= 1. Claim takes priority over a simultaneous write to r, because the new producer supersedes the old one.
  - Otherwise, any WrEn[j] with WrAddr[j]==r: busy[r] <= 0.
  - Otherwise busy[r] holds.
  - A claim of an already-busy register stays busy (no count; one producer outstanding per register is the issue-logic contract).
- RdBusy[i]:
  - BYPASS=0: busy[RdAddr[i]].
  - BYPASS=1: busy[RdAddr[i]] AND NOT (some WrEn[j] targets RdAddr[i] this cycle). The value is being delivered via bypass, so no stall is needed.
  - RdBusy ignores same-cycle ClaimEn (a claim becomes visible next cycle).
- A write to a non-busy register is legal: data updates and busy stays 0.
- Widths: all indices are unsigned. No arithmetic. No out-of-range index exists, since depth = 2**ADDR_W.

Test Plan:
1. Reset then read all ports: RESET=1 for 1 edge, RdAddr={1,2,3} -> RdData all 0, RdBusy all 0. Write r5=0xDEADBEEF while RESET=1 -> r5 still 0 after reset drops.
2. Bypass vs no bypass: WrEn[0]=1, WrAddr=7, WrData=0x12345678, RdAddr[0]=7 in the same cycle -> BYPASS=1 gives RdData[0]=0x12345678 that cycle; BYPASS=0 gives the old value that cycle and 0x12345678 next cycle.
3. Write collision: ports 0 and 1 both write r9 with 0x1111 and 0x2222 -> r9=0x2222; the bypass read that cycle also returns 0x2222.
4. Zero register: write r0=0xFFFFFFFF and ClaimReg=0 -> RdData for r0 = 0, RdBusy 0 (ZERO_REG=1). Rerun with ZERO_REG=0 -> reads 0xFFFFFFFF.
5. Scoreboard, step by step:
   - Claim r4 -> next cycle RdBusy=1 for r4.
   - Write r4=0xAB -> RdBusy=0 that cycle (BYPASS=1) and afterwards.
   - Claim r4 and write r4 in the same cycle -> r4=new data, busy stays 1.
6. Reset mid-flight: claim r3, r8, then RESET=1 for one edge with a simultaneous write to r3 -> all busy 0, r3=0, r8=0.
